// File: rtl/ahb_master_arbiter_if.sv
// AHB-Lite manager-side bus bundle shared by ahb_master_arbiter and its subordinate.
interface ahb_master_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic [1:0]            HRESP;
    logic                  HREADY;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HRESP, HREADY
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HRESP, HREADY
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-requester AHB-Lite manager issuing single NONSEQ transfers.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to requester 0.
module ahb_master_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic                  write0,
    input  logic                  write1,
    input  logic [2:0]            size0,
    input  logic [2:0]            size1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    ahb_master_arbiter_if.master  ahb
);
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [DATA_WIDTH-1:0] wdata;
    } payload_t;

    state_t                state_q, state_d;
    payload_t              pl_q, pl_d;
    logic                  win_q, win_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic [1:0]            done_q, done_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    payload_t pay0_c, pay1_c;
    logic     grant_c;
    logic     win_c;
    logic     unused_hresp_c;

    assign pay0_c         = {addr0, write0, size0, wdata0};
    assign pay1_c         = {addr1, write1, size1, wdata1};
    assign unused_hresp_c = ahb.HRESP[1];

    // Arbitration is blocked while done is high so a held req is not reissued.
    assign grant_c = (state_q == S_IDLE) && (|req) && (done_q == 2'b00) && ahb.HREADY;

`ifdef AHB_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // Contention goes to whoever did not win last; a lone request always wins.
    assign win_c  = (&req) ? ~last_q : ~req[0];
    assign last_d = grant_c ? win_c : last_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win_c = ~req[0];
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            pl_q     <= '0;
            win_q    <= 1'b0;
            htrans_q <= TRANS_IDLE;
            hwdata_q <= '0;
            done_q   <= 2'b00;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pl_q     <= pl_d;
            win_q    <= win_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pl_d     = pl_q;
        win_d    = win_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        done_d   = 2'b00;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    state_d  = S_ADDR;
                    win_d    = win_c;
                    pl_d     = win_c ? pay1_c : pay0_c;
                    htrans_d = TRANS_NONSEQ;
                end
            end
            S_ADDR: begin
                if (ahb.HREADY) begin
                    state_d  = S_DATA;
                    htrans_d = TRANS_IDLE;
                    hwdata_d = pl_q.write ? pl_q.wdata : '0;
                end
            end
            S_DATA: begin
                if (ahb.HREADY) begin
                    state_d  = S_IDLE;
                    hwdata_d = '0;
                    done_d   = win_q ? 2'b10 : 2'b01;
                    err_d    = ahb.HRESP[0];
                    if (!pl_q.write) begin
                        rdata_d = ahb.HRDATA;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                htrans_d = TRANS_IDLE;
            end
        endcase
    end

    assign ahb.HADDR  = pl_q.addr;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HWRITE = pl_q.write;
    assign ahb.HSIZE  = pl_q.size;
    assign ahb.HBURST = 3'b000;
    assign ahb.HPROT  = 4'b0011;
    assign ahb.HWDATA = hwdata_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign err        = err_q;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter; completions are checked against a queue of expected results.
module tb_ahb_master_arbiter;
    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  req;
    logic [31:0] addr0, addr1;
    logic        write0, write1;
    logic [2:0]  size0, size1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        err;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ahb_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ahb ();

    ahb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .req     (req),
        .addr0   (addr0),
        .addr1   (addr1),
        .write0  (write0),
        .write1  (write1),
        .size0   (size0),
        .size1   (size1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .done    (done),
        .rdata   (rdata),
        .err     (err),
        .ahb     (ahb.master)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a done pulse, checks its latency, then scores it against the queue head.
    task automatic wait_done(input string tag, input int exp_cyc);
        int   n;
        exp_t e;
        n = 0;
        do begin
            tick();
            n++;
        end while (done === 2'b00 && n < 20);
        check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
        check({tag, "_sb_pending"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_done"},  64'(done),  64'(e.done));
            check({tag, "_rdata"}, 64'(rdata), 64'(e.rdata));
            check({tag, "_err"},   64'(err),   64'(e.err));
        end
    endtask

    initial begin
        HRESETn = 1'b0;
        req = 2'b00;
        addr0 = '0; addr1 = '0; write0 = 1'b0; write1 = 1'b0;
        size0 = '0; size1 = '0; wdata0 = '0; wdata1 = '0;
        ahb.HREADY = 1'b1; ahb.HRESP = 2'b00; ahb.HRDATA = '0;

        // Reset values
        tick(); tick();
        check("rst_htrans", 64'(ahb.HTRANS), 64'h0);
        check("rst_haddr",  64'(ahb.HADDR),  64'h0);
        check("rst_hwrite", 64'(ahb.HWRITE), 64'h0);
        check("rst_hsize",  64'(ahb.HSIZE),  64'h0);
        check("rst_hburst", 64'(ahb.HBURST), 64'h0);
        check("rst_hprot",  64'(ahb.HPROT),  64'h3);
        check("rst_hwdata", 64'(ahb.HWDATA), 64'h0);
        check("rst_done",   64'(done),       64'h0);
        check("rst_rdata",  64'(rdata),      64'h0);
        check("rst_err",    64'(err),        64'h0);
        HRESETn = 1'b1;
        tick();

        // Zero-wait write from requester 0; payload change after grant must be ignored
        addr0 = 32'h10; write0 = 1'b1; size0 = 3'd2; wdata0 = 32'hA5A5_A5A5; req = 2'b01;
        sb.push_back('{done: 2'b01, rdata: 32'h0, err: 1'b0});
        tick();
        check("wr0_htrans", 64'(ahb.HTRANS), 64'h2);
        check("wr0_haddr",  64'(ahb.HADDR),  64'h10);
        check("wr0_hwrite", 64'(ahb.HWRITE), 64'h1);
        check("wr0_hsize",  64'(ahb.HSIZE),  64'h2);
        check("wr0_hburst", 64'(ahb.HBURST), 64'h0);
        check("wr0_hprot",  64'(ahb.HPROT),  64'h3);
        addr0 = 32'hFF; wdata0 = 32'h0;
        tick();
        check("wr0_data_htrans", 64'(ahb.HTRANS), 64'h0);
        check("wr0_hwdata",      64'(ahb.HWDATA), 64'hA5A5_A5A5);
        check("wr0_haddr_held",  64'(ahb.HADDR),  64'h10);
        wait_done("wr0", 1);
        req = 2'b00;
        tick();
        check("wr0_done_clear", 64'(done), 64'h0);

        // Read from requester 1 with two wait states in the data phase
        addr1 = 32'h20; write1 = 1'b0; size1 = 3'd2; ahb.HRDATA = 32'h1234_5678; req = 2'b10;
        sb.push_back('{done: 2'b10, rdata: 32'h1234_5678, err: 1'b0});
        tick();
        check("rd1_htrans", 64'(ahb.HTRANS), 64'h2);
        check("rd1_haddr",  64'(ahb.HADDR),  64'h20);
        check("rd1_hwrite", 64'(ahb.HWRITE), 64'h0);
        tick();
        check("rd1_hwdata_zero", 64'(ahb.HWDATA), 64'h0);
        ahb.HREADY = 1'b0;
        tick();
        check("rd1_wait1_done", 64'(done), 64'h0);
        tick();
        check("rd1_wait2_done", 64'(done), 64'h0);
        ahb.HREADY = 1'b1;
        wait_done("rd1", 1);
        req = 2'b00;
        tick();

        // Two-cycle ERROR response on a read from requester 0
        addr0 = 32'h30; write0 = 1'b0; ahb.HRDATA = 32'hDEAD_BEEF; req = 2'b01;
        sb.push_back('{done: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b1});
        tick();
        tick();
        ahb.HRESP = 2'b01; ahb.HREADY = 1'b0;
        tick();
        check("errrsp_htrans", 64'(ahb.HTRANS), 64'h0);
        check("errrsp_done",   64'(done),       64'h0);
        ahb.HREADY = 1'b1;
        wait_done("errrsp", 1);
        check("errrsp_htrans_end", 64'(ahb.HTRANS), 64'h0);
        ahb.HRESP = 2'b00; req = 2'b00;
        tick();

        // Write from requester 1: rdata must keep its previous value
        addr1 = 32'h40; write1 = 1'b1; wdata1 = 32'h0BAD_F00D; ahb.HRDATA = 32'h5555_5555; req = 2'b10;
        sb.push_back('{done: 2'b10, rdata: 32'hDEAD_BEEF, err: 1'b0});
        tick();
        tick();
        check("wr1_hwdata", 64'(ahb.HWDATA), 64'h0BAD_F00D);
        wait_done("wr1", 1);
        req = 2'b00;
        tick();

        // Both requesters held for four transfers
        addr0 = 32'h100; write0 = 1'b1; wdata0 = 32'h1111_1111;
        addr1 = 32'h200; write1 = 1'b1; wdata1 = 32'h2222_2222;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef AHB_ARB_ROUND_ROBIN_EN
            sb.push_back('{done: (k % 2 == 0) ? 2'b01 : 2'b10, rdata: 32'hDEAD_BEEF, err: 1'b0});
`else
            sb.push_back('{done: 2'b01, rdata: 32'hDEAD_BEEF, err: 1'b0});
`endif
            wait_done($sformatf("both_%0d", k), (k == 0) ? 3 : 4);
        end
        req = 2'b00;
        tick();
        tick();
        check("both_idle_htrans", 64'(ahb.HTRANS), 64'h0);
        check("both_idle_done",   64'(done),       64'h0);

        // Reset during the data phase aborts the transfer
        addr0 = 32'h50; write0 = 1'b1; wdata0 = 32'h7777_7777; req = 2'b01;
        tick();
        tick();
        check("abort_in_data", 64'(ahb.HWDATA), 64'h7777_7777);
        HRESETn = 1'b0;
        tick();
        check("abort_htrans", 64'(ahb.HTRANS), 64'h0);
        check("abort_done",   64'(done),       64'h0);
        check("abort_haddr",  64'(ahb.HADDR),  64'h0);
        check("abort_hwdata", 64'(ahb.HWDATA), 64'h0);
        check("abort_rdata",  64'(rdata),      64'h0);
        HRESETn = 1'b1; req = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("abort_nodone_%0d", k), 64'(done), 64'h0);
        end
        check("sb_empty", 64'(sb.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001: Parameter ADDR_WIDTH, default 32, HADDR and requester address width.
REQ-002: Parameter DATA_WIDTH, default 32, HWDATA/HRDATA and requester data width.
REQ-003: HCLK  input  1  single clock; all logic on rising edge.
REQ-004: HRESETn  input  1  reset; synchronous, active-low.
REQ-005: req[1:0]  input  2  per-requester transfer request, held until done.
REQ-006: addr0, addr1  input  ADDR_WIDTH each  requester address.
REQ-007: write0, write1  input  1 each  1 = write, 0 = read.
REQ-008: size0, size1  input  3 each  HSIZE value.
REQ-009: wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-010: done[1:0]  output  2  one-cycle completion pulse per requester.
REQ-011: rdata  output  DATA_WIDTH  captured HRDATA, valid while done is nonzero.
REQ-012: err  output  1  ERROR response flag, valid while done is nonzero.
REQ-013: HADDR, HTRANS[1:0], HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HWDATA  outputs  AHB-Lite manager signals.
REQ-014: HRDATA  input  DATA_WIDTH; HRESP[1:0]  input, bit0 = ERROR; HREADY  input  1.

Function
REQ-015: The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-016: IDLE SHALL drive HTRANS=IDLE(00); on a rising edge with any req bit set, done==0 and HREADY==1, it SHALL latch the winner's payload and go to ADDR.
REQ-017: ADDR SHALL drive HTRANS=NONSEQ(10), HBURST=SINGLE(000), HPROT=0011 and the latched HADDR/HWRITE/HSIZE, and go to DATA at the first edge with HREADY==1.
REQ-018: DATA SHALL drive HTRANS=IDLE and HWDATA=latched wdata (0 for reads), and wait for an edge with HREADY==1.
REQ-019: On that DATA edge the FSM SHALL register rdata=HRDATA (reads only; rdata holds its prior value on writes), err=HRESP[0], pulse done[winner] for exactly one cycle, and return to IDLE.
REQ-020: Minimum latency from req sampled to done SHALL be 3 cycles with zero wait states; each HREADY-low cycle adds one.
REQ-021: In IDLE the FSM SHALL NOT arbitrate in a cycle where done is nonzero, so no transfer is issued twice.
REQ-022: On a two-cycle ERROR response (HRESP[0]=1 with HREADY=0, then HREADY=1), the FSM SHALL hold HTRANS=IDLE and complete with err=1.
REQ-023: Payload inputs SHALL be sampled only at grant; changes after grant have no effect.
REQ-024: Arbitration SHALL follow the configured policy of REQ-027.

Reset
REQ-025: With HRESETn==0 at an edge: state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HBURST=000, HPROT=0011, HWDATA=0, done=00, rdata=0, err=0, last-grant pointer=1.
REQ-026: A reset asserted in ADDR or DATA SHALL abort the transfer without a done pulse.

Configuration
REQ-027: Macro AHB_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL be granted to the requester that did not win most recently, and the pointer updates on each grant; when undefined, requester 0 SHALL always win (fixed priority) and the pointer logic is omitted.

Verification
REQ-028: req=01, write0=1, addr0=0x10, wdata0=0xA5A5A5A5, HREADY=1 -> NONSEQ on HADDR=0x10 in cycle 2, HWDATA=0xA5A5A5A5 in cycle 3, done=01, err=0 in cycle 4.
REQ-029: Read from addr1=0x20 with HRDATA=0x12345678 and 2 wait states in DATA -> done=10 in cycle 6, rdata=0x12345678.
REQ-030: req=11 held for 4 transfers -> with the macro, grants 0,1,0,1; without it, grants 0,0,0,0.
REQ-031: HRESP=01 with HREADY=0 for 1 cycle, then HREADY=1 -> HTRANS stays 00, done pulses, err=1.
REQ-032: HRESETn=0 while in DATA -> next cycle state=IDLE, HTRANS=00, done=00, and no done pulse afterwards.
